// File: rtl/chip_pkg.sv
// chip_pkg: shared host FSM states, memory select codes and an index-width helper.
package chip_pkg;
  typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST, WR_RESP} host_state_e;
  localparam logic SEL_IMEM = 1'b0;
  localparam logic SEL_DMEM = 1'b1;
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/chip_mem.sv
// chip_mem: 1-read/1-write synchronous RAM with byte-enable writes and an enabled, resettable read register.
module chip_mem import chip_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 128,
  parameter int AW = idx_w(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [WIDTH/8-1:0] be,
  input  logic [AW-1:0]      waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic               re,
  input  logic [AW-1:0]      raddr,
  output logic [WIDTH-1:0]   rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we)
      for (int i = 0; i < WIDTH/8; i++)
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
  always_ff @(posedge clk)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/chip_top.sv
// chip_top: instruction/data memories with core fetch and load/store ports plus a host burst port.
// Define CHIP_BOUNDS_ERR_EN to add the sticky host_err output and out-of-range burst suppression.
module chip_top import chip_pkg::*; #(
  parameter int INST_WIDTH         = 32,
  parameter int INST_ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH         = 32,
  parameter int DATA_ADDR_WIDTH    = 32,
  parameter int NUM_WORDS_INST_MEM = 128,
  parameter int NUM_WORDS_DATA_MEM = 128,
  parameter int READ_BURST_LEN     = 8,
  parameter int WRITE_BURST_LEN    = 8
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic                       host_req_valid,
  output logic                       host_req_ready,
  input  logic                       host_req_write,
  input  logic                       host_req_sel,
  input  logic [DATA_ADDR_WIDTH-1:0] host_req_addr,
  input  logic                       host_wdata_valid,
  output logic                       host_wdata_ready,
  input  logic [DATA_WIDTH-1:0]      host_wdata,
  output logic                       host_wdone,
  output logic                       host_rdata_valid,
  input  logic                       host_rdata_ready,
  output logic [DATA_WIDTH-1:0]      host_rdata,
  output logic                       host_rdata_last,
  input  logic [INST_ADDR_WIDTH-1:0] if_addr,
  output logic [INST_WIDTH-1:0]      if_inst,
  output logic                       if_stall,
  input  logic                       dm_en,
  input  logic                       dm_we,
  input  logic [DATA_WIDTH/8-1:0]    dm_be,
  input  logic [DATA_ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0]      dm_wdata,
  output logic [DATA_WIDTH-1:0]      dm_rdata,
  output logic                       dm_stall
`ifdef CHIP_BOUNDS_ERR_EN
  , output logic                     host_err
`endif
);
  localparam int IIW = idx_w(NUM_WORDS_INST_MEM);
  localparam int DIW = idx_w(NUM_WORDS_DATA_MEM);
  localparam int HW = (IIW > DIW) ? IIW : DIW;
  localparam int CW = idx_w((READ_BURST_LEN > WRITE_BURST_LEN) ? READ_BURST_LEN : WRITE_BURST_LEN);
  localparam logic [DATA_ADDR_WIDTH-1:0] I_DEPTH = DATA_ADDR_WIDTH'(NUM_WORDS_INST_MEM);
  localparam logic [DATA_ADDR_WIDTH-1:0] D_DEPTH = DATA_ADDR_WIDTH'(NUM_WORDS_DATA_MEM);
  host_state_e state;
  logic sel, bad, rvalid, host_fire, h_re, h_we, i_host, d_host;
  logic [HW-1:0] h_idx, h_last, next_idx, req_idx;
  logic [CW-1:0] cnt;
  logic [DATA_ADDR_WIDTH-1:0] req_word, req_depth;
  logic [IIW-1:0] if_idx;
  logic [DIW-1:0] dm_idx;
  logic [INST_WIDTH-1:0] imem_q, if_hold;
  logic [DATA_WIDTH-1:0] dmem_q, dm_hold;
  assign req_word  = host_req_addr >> 2;
  assign req_depth = host_req_sel ? D_DEPTH : I_DEPTH;
  assign req_idx   = HW'(req_word % req_depth);
  assign if_idx    = IIW'((if_addr >> 2) % INST_ADDR_WIDTH'(NUM_WORDS_INST_MEM));
  assign dm_idx    = DIW'((dm_addr >> 2) % D_DEPTH);
  assign h_last    = sel ? HW'(NUM_WORDS_DATA_MEM - 1) : HW'(NUM_WORDS_INST_MEM - 1);
  assign next_idx  = (h_idx == h_last) ? '0 : h_idx + 1'b1;
  assign host_req_ready   = (state == IDLE) && !sys_rst;
  assign host_wdata_ready = state == WR_BURST;
  assign host_wdone       = state == WR_RESP;
  assign host_rdata_valid = rvalid;
  assign host_rdata_last  = rvalid && (cnt == CW'(READ_BURST_LEN - 1));
  assign host_rdata       = bad ? '0 : (sel ? dmem_q : DATA_WIDTH'(imem_q));
  assign if_stall  = (state != IDLE) && (sel == SEL_IMEM);
  assign dm_stall  = (state != IDLE) && (sel == SEL_DMEM);
  assign host_fire = host_req_valid && host_req_ready;
  assign h_re      = (state == RD_BURST) && !rvalid;
  assign h_we      = (state == WR_BURST) && host_wdata_valid && !bad;
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      state  <= IDLE;
      sel    <= SEL_IMEM;
      h_idx  <= '0;
      cnt    <= '0;
      rvalid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (host_req_valid) begin
          sel   <= host_req_sel;
          h_idx <= req_idx;
          cnt   <= '0;
          state <= host_req_write ? WR_BURST : RD_BURST;
        end
        WR_BURST: if (host_wdata_valid) begin
          h_idx <= next_idx;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WRITE_BURST_LEN - 1)) state <= WR_RESP;
        end
        WR_RESP: state <= IDLE;
        RD_BURST:
          if (!rvalid) rvalid <= 1'b1;
          else if (host_rdata_ready) begin
            rvalid <= 1'b0;
            h_idx  <= next_idx;
            cnt    <= cnt + 1'b1;
            if (cnt == CW'(READ_BURST_LEN - 1)) state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
`ifdef CHIP_BOUNDS_ERR_EN
  logic [DATA_ADDR_WIDTH:0] req_end;
  logic oob;
  assign req_end = {1'b0, req_word} + (DATA_ADDR_WIDTH+1)'(host_req_write ? WRITE_BURST_LEN : READ_BURST_LEN);
  assign oob = req_end > {1'b0, req_depth};
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      bad      <= 1'b0;
      host_err <= 1'b0;
    end else if (host_fire) begin
      bad      <= oob;
      host_err <= host_err | oob;
    end
`else
  assign bad = 1'b0;
`endif
  // The read registers are shared with host reads, so remember who loaded them last and replay the core's value while the host owns them.
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      i_host  <= 1'b0;
      d_host  <= 1'b0;
      if_hold <= '0;
      dm_hold <= '0;
    end else begin
      if (!if_stall || h_re) i_host <= if_stall;
      if (dm_stall ? h_re : (dm_en && !dm_we)) d_host <= dm_stall;
      if_hold <= if_inst;
      dm_hold <= dm_rdata;
    end
  assign if_inst  = i_host ? if_hold : imem_q;
  assign dm_rdata = d_host ? dm_hold : dmem_q;
  chip_mem #(.WIDTH(INST_WIDTH), .DEPTH(NUM_WORDS_INST_MEM), .AW(IIW)) u_imem (
    .clk(sys_clk), .rst(sys_rst),
    .we(if_stall && h_we), .be('1), .waddr(IIW'(h_idx)), .wdata(INST_WIDTH'(host_wdata)),
    .re(!if_stall || h_re), .raddr(if_stall ? IIW'(h_idx) : if_idx), .rdata(imem_q)
  );
  chip_mem #(.WIDTH(DATA_WIDTH), .DEPTH(NUM_WORDS_DATA_MEM), .AW(DIW)) u_dmem (
    .clk(sys_clk), .rst(sys_rst),
    .we(dm_stall ? h_we : (dm_en && dm_we)), .be(dm_stall ? '1 : dm_be),
    .waddr(dm_stall ? DIW'(h_idx) : dm_idx), .wdata(dm_stall ? host_wdata : dm_wdata),
    .re(dm_stall ? h_re : (dm_en && !dm_we)), .raddr(dm_stall ? DIW'(h_idx) : dm_idx), .rdata(dmem_q)
  );
endmodule

// File: tb/tb_chip_top.sv
// tb_chip_top: directed self-checking bench for the chip memory subsystem.
module tb_chip_top;
  logic sys_clk = 1'b0, sys_rst = 1'b1;
  logic host_req_valid = 0, host_req_ready, host_req_write = 0, host_req_sel = 0;
  logic [31:0] host_req_addr = 0;
  logic host_wdata_valid = 0, host_wdata_ready, host_wdone;
  logic [31:0] host_wdata = 0;
  logic host_rdata_valid, host_rdata_ready = 0, host_rdata_last;
  logic [31:0] host_rdata;
  logic [31:0] if_addr = 0, if_inst;
  logic if_stall;
  logic dm_en = 0, dm_we = 0, dm_stall;
  logic [3:0] dm_be = 0;
  logic [31:0] dm_addr = 0, dm_wdata = 0, dm_rdata;
`ifdef CHIP_BOUNDS_ERR_EN
  logic host_err;
`endif
  int checks = 0, failures = 0;
  logic [31:0] ev [8];

  chip_top dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
    .host_req_write(host_req_write), .host_req_sel(host_req_sel), .host_req_addr(host_req_addr),
    .host_wdata_valid(host_wdata_valid), .host_wdata_ready(host_wdata_ready),
    .host_wdata(host_wdata), .host_wdone(host_wdone),
    .host_rdata_valid(host_rdata_valid), .host_rdata_ready(host_rdata_ready),
    .host_rdata(host_rdata), .host_rdata_last(host_rdata_last),
    .if_addr(if_addr), .if_inst(if_inst), .if_stall(if_stall),
    .dm_en(dm_en), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_stall(dm_stall)
`ifdef CHIP_BOUNDS_ERR_EN
    , .host_err(host_err)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic hw(input logic s, input logic [31:0] a, input logic [31:0] d0);
    host_req_valid = 1; host_req_write = 1; host_req_sel = s; host_req_addr = a;
    tick();
    host_req_valid = 0;
    chk("wr_if_stall", if_stall, !s);
    chk("wr_dm_stall", dm_stall, s);
    host_wdata_valid = 1;
    for (int i = 0; i < 8; i++) begin
      host_wdata = d0 + i;
      chk("wr_ready", host_wdata_ready, 1);
      chk("wr_done_early", host_wdone, 0);
      tick();
    end
    host_wdata_valid = 0;
    chk("wr_done", host_wdone, 1);
    tick();
    chk("wr_done_once", host_wdone, 0);
    chk("wr_back_idle", host_req_ready, 1);
  endtask

  task automatic hr(input logic s, input logic [31:0] a, input logic [31:0] exp_d [8], input int hold_beat);
    int n;
    host_req_valid = 1; host_req_write = 0; host_req_sel = s; host_req_addr = a;
    tick();
    host_req_valid = 0; host_rdata_ready = 1;
    for (int i = 0; i < 8; i++) begin
      n = 0;
      while (!host_rdata_valid && n < 10) begin
        tick();
        n++;
      end
      chk("rd_valid", host_rdata_valid, 1);
      chk("rd_data", host_rdata, exp_d[i]);
      chk("rd_last", host_rdata_last, i == 7);
      if (i == hold_beat) begin
        host_rdata_ready = 0;
        for (int k = 0; k < 3; k++) begin
          tick();
          chk("rd_hold_valid", host_rdata_valid, 1);
          chk("rd_hold_data", host_rdata, exp_d[i]);
        end
        host_rdata_ready = 1;
      end
      tick();
    end
    host_rdata_ready = 0;
    chk("rd_back_idle", host_req_ready, 1);
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    dm_en = 1; dm_we = 1; dm_addr = a; dm_wdata = d; dm_be = be;
    tick();
    dm_en = 0; dm_we = 0;
  endtask

  task automatic ld(input string tag, input logic [31:0] a, input logic [31:0] exp_v);
    dm_en = 1; dm_we = 0; dm_addr = a;
    tick();
    dm_en = 0;
    chk(tag, dm_rdata, exp_v);
  endtask

  initial begin
    tick();
    chk("rst_req_ready", host_req_ready, 0);
    chk("rst_if_stall", if_stall, 0);
    chk("rst_dm_stall", dm_stall, 0);
    chk("rst_if_inst", if_inst, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_rvalid", host_rdata_valid, 0);
    chk("rst_wdone", host_wdone, 0);
    tick();
    chk("rst_req_ready2", host_req_ready, 0);
    sys_rst = 0;
    tick();
    chk("idle_req_ready", host_req_ready, 1);
    hw(0, 32'h0, 32'h100);
    if_addr = 32'h1C;
    tick();
    chk("fetch_1c", if_inst, 32'h107);
    if_addr = 32'h2;
    tick();
    chk("fetch_lowbits", if_inst, 32'h100);
    for (int i = 0; i < 8; i++) st(32'h20 + 4*i, 32'hA0 + i, 4'hF);
    for (int i = 0; i < 8; i++) ev[i] = 32'hA0 + i;
    hr(1, 32'h20, ev, 2);
    st(32'h60, 32'h11223344, 4'hF);
    st(32'h60, 32'hAABBCCDD, 4'b0101);
    ld("byte_en", 32'h63, 32'h11BB33DD);
    st(32'h80, 32'h12345678, 4'hF);
    ld("pre_store", 32'h80, 32'h12345678);
    host_req_valid = 1; host_req_write = 1; host_req_sel = 1; host_req_addr = 32'h40;
    tick();
    host_req_valid = 0;
    chk("iso_dm_stall", dm_stall, 1);
    chk("iso_if_stall", if_stall, 0);
    host_wdata_valid = 1; host_wdata = 32'hB0;
    dm_en = 1; dm_we = 1; dm_be = 4'hF; dm_addr = 32'h80; dm_wdata = 32'hDEAD; if_addr = 32'h8;
    tick();
    chk("iso_fetch_8", if_inst, 32'h102);
    host_wdata = 32'hB1; dm_we = 0; dm_addr = 32'h60; if_addr = 32'hC;
    tick();
    chk("iso_fetch_c", if_inst, 32'h103);
    chk("iso_load_held", dm_rdata, 32'h12345678);
    dm_en = 0;
    for (int i = 2; i < 8; i++) begin
      host_wdata = 32'hB0 + i;
      tick();
    end
    host_wdata_valid = 0;
    chk("iso_wdone", host_wdone, 1);
    tick();
    chk("iso_stall_clear", dm_stall, 0);
    ld("store_dropped", 32'h80, 32'h12345678);
    ld("dm_burst_last", 32'h5C, 32'hB7);
    hw(0, 32'h1F0, 32'h300);
    for (int i = 0; i < 8; i++) ev[i] = (i < 4) ? 32'h304 + i : 32'h100 + i;
    hr(0, 32'h0, ev, -1);
    for (int i = 0; i < 8; i++) ev[i] = 32'h300 + i;
    hr(0, 32'h1F0, ev, -1);
    if_addr = 32'h1FC;
    tick();
    chk("fetch_wrap_top", if_inst, 32'h303);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/chip_top.md
Name: chip_top

Overview:
- Single-clock memory subsystem at the top of the RISC-V chip.
- Holds the instruction memory and the data memory.
- Gives the CPU core a fetch port and a load/store port.
- Gives the host/loader a burst read/write port into either memory.
- The host has priority: a host burst stalls core access to the targeted memory only.

Parameters:
- INST_WIDTH, 32, instruction word width.
- INST_ADDR_WIDTH, 32, fetch byte-address width.
- DATA_WIDTH, 32, data word width.
- DATA_ADDR_WIDTH, 32, data/host byte-address width.
- NUM_WORDS_INST_MEM, 128, instruction memory depth in words.
- NUM_WORDS_DATA_MEM, 128, data memory depth in words.
- READ_BURST_LEN, 8, beats per host read burst.
- WRITE_BURST_LEN, 8, beats per host write burst.

Ports:
- sys_clk  in  1  sole clock, rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- host_req_valid  in  1  burst request valid.
- host_req_ready  out  1  request accepted (IDLE only).
- host_req_write  in  1  1 = write burst, 0 = read burst.
- host_req_sel  in  1  0 = instruction memory, 1 = data memory.
- host_req_addr  in  DATA_ADDR_WIDTH  word-aligned start byte address.
- host_wdata_valid  in  1  write beat valid.
- host_wdata_ready  out  1  write beat accepted.
- host_wdata  in  DATA_WIDTH  write beat data.
- host_wdone  out  1  one-cycle pulse after the last write beat.
- host_rdata_valid  out  1  read beat valid.
- host_rdata_ready  in  1  host accepts read beat.
- host_rdata  out  DATA_WIDTH  read beat data.
- host_rdata_last  out  1  final read beat.
- if_addr  in  INST_ADDR_WIDTH  fetch byte address.
- if_inst  out  INST_WIDTH  fetched instruction, registered.
- if_stall  out  1  fetch blocked by a host burst to instruction memory.
- dm_en  in  1  data access enable.
- dm_we  in  1  store.
- dm_be  in  DATA_WIDTH/8  byte enables for stores.
- dm_addr  in  DATA_ADDR_WIDTH  data byte address.
- dm_wdata  in  DATA_WIDTH  store data.
- dm_rdata  out  DATA_WIDTH  load data, registered.
- dm_stall  out  1  data access blocked by a host burst to data memory.

Behaviour:
- Addressing: word index = addr >> 2, taken modulo the memory depth. Address bits [1:0] are ignored.
- Fetch: if_inst = imem[if_addr index], available 1 cycle after if_addr is presented. If if_stall=1, if_inst holds its previous value.
- Load: dm_en & ~dm_we gives dm_rdata one cycle later. While stalled, dm_rdata holds.
- Store: dm_en & dm_we writes only the lanes with dm_be set, in the same edge. A stalled store is dropped; the core must retry.
- Host FSM states: IDLE, WR_BURST, RD_BURST, WR_RESP.
- IDLE: host_req_ready=1. On valid&ready, latch sel and word index, clear the beat counter, then go to WR_BURST or RD_BURST.
- WR_BURST: host_wdata_ready=1. Each valid&ready beat writes the full word, then index increments modulo depth (wrap-around). After WRITE_BURST_LEN beats, go to WR_RESP.
- WR_RESP: host_wdone=1 for exactly one cycle, then go to IDLE.
- RD_BURST: a 1-cycle memory read precedes each beat. host_rdata_valid stays high until the handshake, and data is stable while ready=0. host_rdata_last=1 on beat READ_BURST_LEN-1. After the last handshake, go to IDLE.
- Stalls: if_stall=1 when the state is not IDLE and sel=0. dm_stall=1 when the state is not IDLE and sel=1. The other memory stays fully usable.
- Reset values: host_req_ready=0 during reset, then 1 (IDLE). All valid/done/last/stall outputs = 0. if_inst and dm_rdata = 0.
- Memory contents are not reset.
- Reset mid-burst aborts to IDLE. Words already written stay written.
- Simultaneous host write and core access to the same memory cannot occur, because the stall blocks the core.

Optional Feature:
- Macro: CHIP_BOUNDS_ERR_EN.
- When defined: adds output host_err (1 bit, sticky, cleared only by reset).
  - A host start word index ≥ depth sets host_err and the request completes with no memory writes.
  - For such a read, all beats return 0.
  - Bursts that cross the end of memory also set host_err, with the same treatment.
- When undefined: no host_err port; all addresses wrap modulo depth.

Decomposition:
- chip_pkg holds:
  - the host FSM state enum;
  - localparams SEL_IMEM=0 and SEL_DMEM=1;
  - a word-index width helper via $clog2.
- Sub-module chip_mem: 1-read/1-write synchronous RAM with byte-enable writes. It is instantiated twice (instruction and data), with a port mux in front of each instance.

Test Plan:
- Reset: assert sys_rst 2 cycles → host_req_ready=0 during reset then 1, all stalls=0, if_inst=0, dm_rdata=0.
- Host write burst to imem at addr 0x0 with data 0x100..0x107 → host_wdone pulses once after beat 8. Fetch at 0x1C then gives if_inst=0x107 one cycle later.
- Host read burst of dmem at 0x20 after core stores 0xA0..0xA7 at 0x20..0x3C → 8 beats equal to 0xA0..0xA7, host_rdata_last only on 0xA7. Holding host_rdata_ready=0 for 3 cycles on beat 2 keeps host_rdata=0xA2 stable.
- Wrap: write burst at 0x1F0 (index 124) → beats 5..8 land at indices 0..3, and a read burst at 0x0 returns them.
- Stall isolation: during a dmem burst, dm_stall=1 and a store of 0xDEAD is dropped. Simultaneously if_stall=0 and fetches return correct data.
- Byte enables: dmem word=0x11223344, store 0xAABBCCDD with dm_be=4'b0101 → reads 0x11BB33DD.
